// File: rtl/matmul_apb_master.sv
// matmul_apb_master: turns single valid/ready commands into APB transfers
// toward the matmul accelerator and returns read data / error status on a
// valid/ready response channel. One transfer outstanding at a time.
//
// Optional feature macro: MATMUL_APB_TIMEOUT_EN
//   defined   -> ACCESS is aborted with err=1 after TIMEOUT_CYC wait cycles
//   undefined -> ACCESS waits for pready_i indefinitely
//
// state  | meaning
// IDLE   | ready for a command (cmd_ready_o=1)
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready_i
// RESP   | response held on rsp_* until rsp_ready_i
module matmul_apb_master #(
    parameter int BUS_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
    input  logic [BUS_WIDTH/8-1:0]  cmd_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [BUS_WIDTH-1:0]    pwdata_o,
    output logic [BUS_WIDTH/8-1:0]  pstrb_o,
    input  logic [BUS_WIDTH-1:0]    prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    if (TIMEOUT_CYC < 1 || (BUS_WIDTH % 8) != 0) begin : g_bad_params
        $error("matmul_apb_master: TIMEOUT_CYC must be >= 1 and BUS_WIDTH a multiple of 8");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [BUS_WIDTH-1:0]    rsp_rdata_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [BUS_WIDTH-1:0]    pwdata_nxt;
    logic [STRB_WIDTH-1:0]   pstrb_nxt;
    logic                    aligned;

`ifdef MATMUL_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

    assign aligned = (cmd_addr_i & ALIGN_MASK) == '0;

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        cmd_ready_nxt = cmd_ready_o;
        rsp_valid_nxt = rsp_valid_o;
        rsp_err_nxt   = rsp_err_o;
        rsp_rdata_nxt = rsp_rdata_o;
        psel_nxt      = psel_o;
        penable_nxt   = penable_o;
        pwrite_nxt    = pwrite_o;
        paddr_nxt     = paddr_o;
        pwdata_nxt    = pwdata_o;
        pstrb_nxt     = pstrb_o;
`ifdef MATMUL_APB_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_ready_nxt = 1'b0;
                    if (aligned) begin
                        state_nxt   = SETUP;
                        psel_nxt    = 1'b1;
                        penable_nxt = 1'b0;
                        pwrite_nxt  = cmd_write_i;
                        paddr_nxt   = cmd_addr_i;
                        // reads put nothing on the write lanes
                        pwdata_nxt  = cmd_write_i ? cmd_wdata_i : '0;
                        pstrb_nxt   = cmd_write_i ? cmd_strb_i : '0;
`ifdef MATMUL_APB_TIMEOUT_EN
                        wait_cnt_nxt = '0;
`endif
                    end else begin
                        // misaligned: answer with an error, no bus activity
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end
                end
            end
            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end
            ACCESS: begin
                if (pready_i) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = pslverr_i;
                    rsp_rdata_nxt = (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                end
`ifdef MATMUL_APB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt     = RESP;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer or response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
`ifdef MATMUL_APB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cmd_ready_o <= cmd_ready_nxt;
            rsp_valid_o <= rsp_valid_nxt;
            rsp_err_o   <= rsp_err_nxt;
            rsp_rdata_o <= rsp_rdata_nxt;
            psel_o      <= psel_nxt;
            penable_o   <= penable_nxt;
            pwrite_o    <= pwrite_nxt;
            paddr_o     <= paddr_nxt;
            pwdata_o    <= pwdata_nxt;
            pstrb_o     <= pstrb_nxt;
`ifdef MATMUL_APB_TIMEOUT_EN
            wait_cnt    <= wait_cnt_nxt;
`endif
        end
    end

endmodule

// File: doc/matmul_apb_master.md
# matmul_apb_master

Command-driven APB initiator that drives the matmul accelerator's APB slave port: it loads operand matrices, programs control registers, and reads back result/scratchpad words. A simple valid/ready command interface on the testbench/host side is converted into single APB transfers. Read data and status return on a valid/ready response channel. This is the requester end of the same APB interface the accelerator responds on.

## Interface
Parameters:
- BUS_WIDTH, 32, APB data width (matches matmul_pkg::BUS_WIDTH)
- ADDR_WIDTH, 32, APB address width (matches matmul_pkg::ADDR_WIDTH)
- TIMEOUT_CYC, 16, max ACCESS cycles before abort (used only with timeout macro)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_write_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_WIDTH  byte address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_strb_i  in  BUS_WIDTH/8  byte strobes
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_rdata_o  out  BUS_WIDTH  read data (0 for writes/errors)
- rsp_err_o  out  1  PSLVERR, misalignment, or timeout
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  BUS_WIDTH  APB write data
- pstrb_o  out  BUS_WIDTH/8  APB strobes
- prdata_i  in  BUS_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: cmd_ready_o=1. On accept, latch command. Go to SETUP if aligned, else RESP with err=1.
- Alignment: addr[log2(BUS_WIDTH/8)-1:0] must be 0. Misaligned commands issue no APB transfer.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb driven from the latched command. Next state: ACCESS.
- ACCESS: psel=1, penable=1, hold all APB outputs stable. On pready_i=1, capture prdata_i (reads only; writes return 0) and pslverr_i, drop psel/penable, then go to RESP.
- RESP: rsp_valid_o=1; data/err held stable until rsp_ready_i=1, then go to IDLE.
- Reads drive pwdata_o=0 and pstrb_o=0. Writes drive the latched wdata/strb.
- cmd_ready_o=0 in every state except IDLE; only one transfer is outstanding.
- pslverr_i is sampled only in the cycle where penable&&pready.

## Timing
- Reset values: cmd_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pstrb_o=0. State=IDLE.
- Zero-wait transfer: accept at edge 0; SETUP visible cycle 1; ACCESS cycle 2 (pready=1); rsp_valid cycle 3. Accept-to-response = 3 cycles.
- Each pready=0 cycle in ACCESS adds 1 cycle.
- Misaligned command: rsp_valid asserted the cycle after accept, with err=1.
- Throughput with rsp_ready tied high: one command per 4 cycles.
- Reset in any state: returns to IDLE on that edge. The APB transfer is abandoned (psel low next cycle) and any pending response is discarded.
- cmd_valid in a non-IDLE state is ignored; the command is not lost, because ready=0.

## Configuration
- MATMUL_APB_TIMEOUT_EN defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC, the block drops psel/penable and enters RESP with err=1, rdata=0.
  - A pready arriving in the same cycle as the limit wins: normal completion.
- Not defined: no counter logic; ACCESS waits indefinitely for pready_i.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF, pready=1 -> SETUP cycle 1 with psel=1, penable=0, pwrite=1, paddr=0x10; ACCESS cycle 2; rsp_valid cycle 3, err=0, rdata=0.
- Read addr 0x20, slave returns 0x01020304 after 3 wait cycles -> penable high 4 cycles, pstrb=0, pwdata=0; rsp_rdata=0x01020304 at cycle 6.
- Read addr 0x22 (misaligned) -> psel never asserts; rsp_valid the next cycle, err=1, rdata=0.
- Write with pslverr=1, pready=1 and rsp_ready held 0 for 5 cycles -> rsp_valid/err=1 stable for 6 cycles; cmd_ready=0 until the handshake completes.
- rst_i pulsed during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1.
- With MATMUL_APB_TIMEOUT_EN, TIMEOUT_CYC=16, pready stuck 0 -> abort after 16 ACCESS cycles, rsp err=1. Without the macro, psel stays high indefinitely.
